rgb565_frame_fifo: RTL and testbench

Frame-buffering synchronous FIFO for RGB565 pixels, sitting directly upstream of the LCD output stage. It stores pixels produced by the capture/CNN side. It drives the empty flag, read data, read-valid and "receive work enable" signals that the LCD stage samples. The receive work enable is held high while a frame is being written, so the LCD stage only drains complete frames.

---
 rtl/rgb565_frame_fifo_pkg.sv | 20 ++
 rtl/rgb565_frame_fifo_sdp_ram.sv | 42 ++++
 rtl/rgb565_frame_fifo.sv | 189 ++++++++++++++++++
 tb/tb_rgb565_frame_fifo.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rgb565_frame_fifo_pkg.sv
// Shared types and constants for the RGB565 frame FIFO: pixel layout and frame FSM encoding.
package rgb565_frame_fifo_pkg;

    localparam int RGB565_W = 16;
    localparam int R_MSB    = 15;
    localparam int G_MSB    = 10;
    localparam int B_MSB    = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } frame_state_e;

    typedef struct packed {
        logic [R_MSB-G_MSB-1:0] r;
        logic [G_MSB-B_MSB-1:0] g;
        logic [B_MSB:0]         b;
    } rgb565_t;

endpackage

// File: rtl/rgb565_frame_fifo_sdp_ram.sv
// Simple dual-port pixel RAM: one write port, one registered read port (1-cycle latency).
// Storage is not reset; only the read output register clears on reset/flush.
module rgb565_frame_fifo_sdp_ram
    import rgb565_frame_fifo_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_clr,
    input  logic                i_we,
    input  logic [AW-1:0]       i_waddr,
    input  logic [RGB565_W-1:0] i_wdata,
    input  logic                i_re,
    input  logic [AW-1:0]       i_raddr,
    output logic [RGB565_W-1:0] o_rdata
);

    logic [RGB565_W-1:0] mem_q [DEPTH];
    logic [RGB565_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    // Output register holds its value between reads so the consumer sees stable data.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            rdata_q <= '0;
        end else if (i_clr) begin
            rdata_q <= '0;
        end else if (i_re) begin
            rdata_q <= mem_q[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/rgb565_frame_fifo.sv
// Synchronous frame-buffering FIFO for RGB565 pixels feeding the LCD stage; registered status flags,
// 1-cycle read latency, and a frame FSM that holds o_rec_work_en high while a frame is being written.
module rgb565_frame_fifo
    import rgb565_frame_fifo_pkg::*;
#(
    parameter int DEPTH        = 1024,
    parameter int AW           = 10,
    parameter int FRAME_PIXELS = 784
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_clr,
    input  logic                i_wr_en,
    input  logic [RGB565_W-1:0] i_wr_data,
    input  logic                i_sof,
    output logic                o_full,
    input  logic                i_rd_en,
    output logic [RGB565_W-1:0] o_rd_data,
    output logic                o_rd_data_vld,
    output logic                o_empty,
    output logic                o_rec_work_en,
    output logic [AW:0]         o_level,
    output logic                o_ovf,
    output logic                o_udf,
    output logic                o_frame_err
);

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] FP_LAST  = (AW+1)'(FRAME_PIXELS);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          vld_q, vld_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          ferr_q, ferr_d;

    frame_state_e  state_q, state_d;
    logic [AW:0]   pcnt_q, pcnt_d;
    logic          restart;
    logic          rec_work_en;

    logic          wr_acc;
    logic          rd_acc;

    assign wr_acc = i_wr_en & ~full_q;
    assign rd_acc = i_rd_en & ~empty_q;

    // Datapath next state; flush wins over any accept in the same cycle.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        vld_d   = 1'b0;
        ovf_d   = ovf_q | (i_wr_en & full_q);
        udf_d   = udf_q | (i_rd_en & empty_q);
        ferr_d  = ferr_q | restart;
        if (wr_acc) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_acc) begin
            rptr_d = rptr_q + 1'b1;
            vld_d  = 1'b1;
        end
        if (wr_acc && !rd_acc) begin
            level_d = level_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            level_d = level_q - 1'b1;
        end
        if (i_clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            vld_d   = 1'b0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
            ferr_d  = 1'b0;
        end
        empty_d = (level_d == '0);
        full_d  = (level_d == LVL_FULL);
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            vld_q   <= vld_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            ferr_q  <= ferr_d;
        end
    end

    // Frame FSM: state register.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
        end
    end

    // Frame FSM: next state. Only accepted writes advance the pixel count.
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        restart = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (wr_acc) begin
                    state_d = ST_RECV;
                    pcnt_d  = (AW+1)'(1);
                end
            end
            ST_RECV: begin
                if (wr_acc) begin
                    if (i_sof && (pcnt_q != '0)) begin
                        restart = 1'b1;
                        pcnt_d  = (AW+1)'(1);
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pcnt_d  = '0;
            end
        endcase
        // A frame closes on the write that reaches FRAME_PIXELS, including a 1-pixel frame.
        if (wr_acc && (pcnt_d == FP_LAST)) begin
            state_d = ST_IDLE;
            pcnt_d  = '0;
        end
        if (i_clr) begin
            state_d = ST_IDLE;
            pcnt_d  = '0;
            restart = 1'b0;
        end
    end

    // Frame FSM: outputs.
    always_comb begin
        rec_work_en = (state_q == ST_RECV);
    end

    rgb565_frame_fifo_sdp_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_clr   (i_clr),
        .i_we    (wr_acc & ~i_clr),
        .i_waddr (wptr_q),
        .i_wdata (i_wr_data),
        .i_re    (rd_acc),
        .i_raddr (rptr_q),
        .o_rdata (o_rd_data)
    );

    assign o_full        = full_q;
    assign o_empty       = empty_q;
    assign o_level       = level_q;
    assign o_rd_data_vld = vld_q;
    assign o_rec_work_en = rec_work_en;
    assign o_ovf         = ovf_q;
    assign o_udf         = udf_q;
    assign o_frame_err   = ferr_q;

endmodule

// File: tb/tb_rgb565_frame_fifo.sv
// Directed bench for rgb565_frame_fifo with hand-computed expectations checked by immediate assertions.
module tb_rgb565_frame_fifo;

    logic        clk;
    logic        i_rst;
    logic        i_clr;
    logic        i_wr_en;
    logic [15:0] i_wr_data;
    logic        i_sof;
    logic        o_full;
    logic        i_rd_en;
    logic [15:0] o_rd_data;
    logic        o_rd_data_vld;
    logic        o_empty;
    logic        o_rec_work_en;
    logic [10:0] o_level;
    logic        o_ovf;
    logic        o_udf;
    logic        o_frame_err;

    int total = 0;
    int bad   = 0;

    rgb565_frame_fifo #(
        .DEPTH        (1024),
        .AW           (10),
        .FRAME_PIXELS (784)
    ) dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_clr         (i_clr),
        .i_wr_en       (i_wr_en),
        .i_wr_data     (i_wr_data),
        .i_sof         (i_sof),
        .o_full        (o_full),
        .i_rd_en       (i_rd_en),
        .o_rd_data     (o_rd_data),
        .o_rd_data_vld (o_rd_data_vld),
        .o_empty       (o_empty),
        .o_rec_work_en (o_rec_work_en),
        .o_level       (o_level),
        .o_ovf         (o_ovf),
        .o_udf         (o_udf),
        .o_frame_err   (o_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic wr, input logic [15:0] d, input logic sof,
                       input logic rd, input logic clr);
        i_wr_en   = wr;
        i_wr_data = d;
        i_sof     = sof;
        i_rd_en   = rd;
        i_clr     = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] exp_d;
        i_rst = 1'b1; i_clr = 1'b0; i_wr_en = 1'b0; i_wr_data = '0; i_sof = 1'b0; i_rd_en = 1'b0;
        #2;
        chk("rst_empty", o_empty, 1);
        chk("rst_full", o_full, 0);
        chk("rst_level", o_level, 0);
        chk("rst_rdata", o_rd_data, 0);
        chk("rst_vld", o_rd_data_vld, 0);
        chk("rst_rec", o_rec_work_en, 0);
        chk("rst_flags", {o_ovf, o_udf, o_frame_err}, 0);
        @(posedge clk); #1;
        i_rst = 1'b0;
        cyc(0, 0, 0, 0, 0);
        chk("idle_rec", o_rec_work_en, 0);

        // One full 784-pixel frame, data = index.
        for (int i = 0; i < 784; i++) begin
            cyc(1, 16'(i), i == 0, 0, 0);
            if (i == 0)   chk("frm_rec_rise", o_rec_work_en, 1);
            if (i == 782) chk("frm_rec_hold", o_rec_work_en, 1);
            if (i == 783) chk("frm_rec_fall", o_rec_work_en, 0);
        end
        chk("frm_level", o_level, 784);
        chk("frm_empty", o_empty, 0);

        // Drain it: each pixel appears one cycle after its read request.
        for (int k = 0; k < 784; k++) begin
            cyc(0, 0, 0, 1, 0);
            chk("drain_vld", o_rd_data_vld, 1);
            chk("drain_data", o_rd_data, k);
        end
        chk("drain_empty", o_empty, 1);
        chk("drain_udf", o_udf, 0);
        cyc(0, 0, 0, 0, 0);
        chk("drain_vld_low", o_rd_data_vld, 0);
        chk("drain_data_hold", o_rd_data, 783);

        // Fill to 1024 with frames of 784 and 240 pixels, then overflow.
        for (int i = 0; i < 1024; i++) begin
            cyc(1, 16'(16'h1000 + i), (i == 0) || (i == 784), 0, 0);
        end
        chk("fill_full", o_full, 1);
        chk("fill_level", o_level, 1024);
        chk("fill_rec", o_rec_work_en, 1);
        chk("fill_ovf_pre", o_ovf, 0);
        cyc(1, 16'hF800, 0, 0, 0);
        chk("ovf_set", o_ovf, 1);
        chk("ovf_level", o_level, 1024);
        chk("ovf_full", o_full, 1);

        // Flush overrides a simultaneous write.
        cyc(1, 16'h1234, 0, 0, 1);
        chk("clr_level", o_level, 0);
        chk("clr_empty", o_empty, 1);
        chk("clr_full", o_full, 0);
        chk("clr_ovf", o_ovf, 0);
        chk("clr_rec", o_rec_work_en, 0);

        // Position the read pointer at 1015 with 5 entries, then read+write across the wrap.
        for (int i = 0; i < 1020; i++) begin
            cyc(1, 16'(i), i == 0, 0, 0);
        end
        for (int k = 0; k < 1015; k++) begin
            cyc(0, 0, 0, 1, 0);
        end
        chk("wrap_level_pre", o_level, 5);
        for (int j = 0; j < 10; j++) begin
            cyc(1, 16'(2000 + j), 0, 1, 0);
            exp_d = (j < 5) ? 16'(1015 + j) : 16'(2000 + j - 5);
            chk("wrap_level", o_level, 5);
            chk("wrap_vld", o_rd_data_vld, 1);
            chk("wrap_data", o_rd_data, exp_d);
        end

        // Mid-frame start-of-frame restarts the pixel count.
        cyc(0, 0, 0, 0, 1);
        chk("clr2_level", o_level, 0);
        for (int i = 0; i < 100; i++) begin
            cyc(1, 16'(i), i == 0, 0, 0);
        end
        chk("ferr_pre", o_frame_err, 0);
        cyc(1, 16'h07E0, 1, 0, 0);
        chk("ferr_set", o_frame_err, 1);
        chk("ferr_rec", o_rec_work_en, 1);
        for (int i = 0; i < 783; i++) begin
            cyc(1, 16'(i), 0, 0, 0);
            if (i == 781) chk("ferr_rec_hold", o_rec_work_en, 1);
        end
        chk("ferr_rec_end", o_rec_work_en, 0);
        chk("ferr_level", o_level, 884);

        // Flush mid-frame at level 300 with sticky flags set.
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        chk("udf_set", o_udf, 1);
        for (int i = 0; i < 300; i++) begin
            cyc(1, 16'(16'h0100 + i), (i == 0) || (i == 150), 0, 0);
        end
        chk("mid_level", o_level, 300);
        chk("mid_flags", {o_udf, o_frame_err, o_rec_work_en}, 3'b111);
        cyc(0, 0, 0, 0, 1);
        chk("mclr_level", o_level, 0);
        chk("mclr_empty", o_empty, 1);
        chk("mclr_rec", o_rec_work_en, 0);
        chk("mclr_flags", {o_ovf, o_udf, o_frame_err}, 0);

        // Asynchronous reset mid-frame clears outputs between clock edges.
        for (int i = 0; i < 300; i++) begin
            cyc(1, 16'(16'h0200 + i), (i == 0) || (i == 10), 0, 0);
        end
        cyc(0, 0, 0, 1, 0);
        chk("pre_rst_data", o_rd_data, 16'h0200);
        chk("pre_rst_ferr", o_frame_err, 1);
        cyc(0, 0, 0, 0, 0);
        #1;
        i_rst = 1'b1;
        #1;
        chk("arst_level", o_level, 0);
        chk("arst_empty", o_empty, 1);
        chk("arst_rec", o_rec_work_en, 0);
        chk("arst_data", o_rd_data, 0);
        chk("arst_flags", {o_ovf, o_udf, o_frame_err}, 0);
        #1;
        i_rst = 1'b0;
        cyc(0, 0, 0, 0, 0);
        chk("post_rst_empty", o_empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
